// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t    : loader FSM encoding (IDLE, LOAD, CHECK, DONE)
//   ROW_DEF    : default imem depth in words
//   WORD_W     : imem word width
//   BYTE_LANES : bytes per imem word
package imem_pkg;
  localparam int ROW_DEF    = 256;
  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Assembles a little-endian word from a byte stream. Lane k receives the
// k-th accepted byte. 'word' always shows the assembly with the current byte
// merged in, so the consumer can register it in the same cycle 'done' pulses.
//   clk, rst_n : clock, async active-low reset
//   clr        : drop any partial word and restart at lane 0
//   accept     : a byte is taken this cycle
//   byte_in    : byte payload
//   word       : assembled word (valid when done=1)
//   done       : last lane is being filled this cycle
module imem_word_packer #(
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   accept,
  input  logic [7:0]             byte_in,
  output logic [NUM_LANES*8-1:0] word,
  output logic                   done
);
  localparam int IDX_W = $clog2(NUM_LANES);

  logic [IDX_W-1:0]           idx;
  logic [NUM_LANES-1:0][7:0]  lanes, lanes_nxt;

  always_comb begin
    lanes_nxt      = lanes;
    lanes_nxt[idx] = byte_in;
  end

  assign word = lanes_nxt;
  assign done = accept && (idx == IDX_W'(NUM_LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      lanes <= '0;
    end else if (clr) begin
      idx   <= '0;
      lanes <= '0;
    end else if (accept) begin
      lanes <= lanes_nxt;
      idx   <= done ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream into 32-bit little-endian words, writes
// them to imem, then opens imem reads and releases the core reset.
// Optional: define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing 4-byte
// checksum (sum of written words mod 2^32) before releasing the core.
//   clk, rst_n        : clock, async active-low reset
//   start, word_count : begin a load of word_count words
//   byte_valid/ready, byte_data : byte stream handshake
//   we, waddr, wdata  : imem write port
//   iready            : imem contents valid
//   cpu_rst_n         : core reset (active-low)
//   busy, err         : load in progress, sticky error
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int ADDR_W = $clog2(ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              iready,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);
  localparam int            CW    = ADDR_W + 1;
  localparam logic [CW-1:0] ROW_C = CW'(ROW);

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d, wcnt, wcnt_d, wcnt_inc;
  logic [WORD_W-1:0]   sum, sum_d, pk_word, wdata_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic                byte_ready_d, we_d, iready_d, cpu_rst_n_d, busy_d, err_d;
  logic                accept, pk_clr, pk_done;

  assign accept   = byte_valid & byte_ready;
  assign wcnt_inc = wcnt + 1'b1;

  imem_word_packer #(.NUM_LANES(BYTE_LANES)) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pk_clr),
    .accept  (accept),
    .byte_in (byte_data),
    .word    (pk_word),
    .done    (pk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      wcnt       <= '0;
      sum        <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      iready     <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      wcnt       <= wcnt_d;
      sum        <= sum_d;
      byte_ready <= byte_ready_d;
      we         <= we_d;
      waddr      <= waddr_d;
      wdata      <= wdata_d;
      iready     <= iready_d;
      cpu_rst_n  <= cpu_rst_n_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    wcnt_d       = wcnt;
    sum_d        = sum;
    byte_ready_d = byte_ready;
    we_d         = 1'b0;
    waddr_d      = waddr;
    wdata_d      = wdata;
    iready_d     = iready;
    cpu_rst_n_d  = cpu_rst_n;
    busy_d       = busy;
    err_d        = err;
    pk_clr       = 1'b0;
    unique case (state)
      // A new start from DONE re-holds the core in the same cycle LOAD begins.
      IDLE, DONE: if (start) begin
        pk_clr       = 1'b1;
        cnt_d        = word_count;
        wcnt_d       = '0;
        sum_d        = '0;
        iready_d     = 1'b0;
        cpu_rst_n_d  = 1'b0;
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;
        if (word_count > ROW_C) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (word_count == '0) begin
          err_d = 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          state_d      = CHECK;
          busy_d       = 1'b1;
          byte_ready_d = 1'b1;
`else
          state_d     = DONE;
          iready_d    = 1'b1;
          cpu_rst_n_d = 1'b1;
`endif
        end else begin
          state_d      = LOAD;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          byte_ready_d = 1'b1;
        end
      end
      // byte_ready is dropped for the write cycle so the write and the next
      // byte never overlap; it returns the cycle after we.
      LOAD: if (we) begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == cnt) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          state_d      = CHECK;
          byte_ready_d = 1'b1;
`else
          state_d     = DONE;
          busy_d      = 1'b0;
          iready_d    = 1'b1;
          cpu_rst_n_d = 1'b1;
`endif
        end else begin
          byte_ready_d = 1'b1;
        end
      end else if (pk_done) begin
        we_d         = 1'b1;
        waddr_d      = wcnt[ADDR_W-1:0];
        wdata_d      = pk_word;
        sum_d        = sum + pk_word;
        byte_ready_d = 1'b0;
      end
      CHECK: if (pk_done) begin
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;
        if (pk_word == sum) begin
          state_d     = DONE;
          iready_d    = 1'b1;
          cpu_rst_n_d = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  localparam int ROW = 256;
  localparam int AW  = 8;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam int CK = 4;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, we, iready, cpu_rst_n, busy, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  always #5 clk = ~clk;

  imem_boot_loader #(.ROW(ROW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .iready(iready),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
  );

  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  wr_t         expq[$];
  logic [31:0] wq[$];
  int npass = 0, ntot = 0, last_addr = -1, cyc = 0, start_cyc = 0, lat = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every imem write must match the next expected one.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && we) begin
      if (expq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_we: addr %h data %h, none expected", waddr, wdata);
      end else begin
        e = expq.pop_front();
        chk("waddr", {24'b0, waddr}, {24'b0, e.a});
        chk("wdata", wdata, e.d);
        last_addr = int'(waddr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left at a negedge.
  task automatic pulse_start(input int wc);
    word_count = (AW+1)'(wc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int bound = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    if (!byte_ready) begin
      ntot++;
      $display("FAIL byte_ready_timeout: byte %h not accepted in 100 cycles", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_idle();
    int bound = 0;
    while (busy && bound < 3000) begin
      @(negedge clk);
      bound++;
    end
    if (busy) begin
      ntot++;
      $display("FAIL busy_timeout: busy still %b after 3000 cycles", busy);
    end
    lat = cyc - start_cyc;
  endtask

  // Loads wq; the checksum (when built in) is the word sum xor ck_flip.
  task automatic do_load(input int gap, input logic [31:0] ck_flip);
    logic [31:0] s;
    wr_t e;
    s = '0;
    pulse_start(wq.size());
    foreach (wq[i]) begin
      e.a = AW'(i);
      e.d = wq[i];
      expq.push_back(e);
      s += wq[i];
      send_word(wq[i], gap);
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send_word(s ^ ck_flip, gap);
`else
    if (ck_flip != 0) s = s ^ ck_flip;
`endif
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_iready", iready, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_waddr", {24'b0, waddr}, 0);
    chk("rst_wdata", wdata, 0);

    // Two words streamed back to back; start edge excluded from the latency.
    wq = {32'h00000013, 32'h00100093};
    do_load(0, 0);
    chk("two_latency", lat, 5*2 + CK);
    chk("two_iready", iready, 1);
    chk("two_cpu_rst_n", cpu_rst_n, 1);
    chk("two_err", err, 0);

    // One byte every three cycles.
    wq = {32'hDEADBEEF};
    do_load(2, 0);
    chk("gap_iready", iready, 1);

    // Over-long count is refused; stray bytes ignored while idle.
    pulse_start(ROW + 1);
    chk("big_err", err, 1);
    chk("big_iready", iready, 0);
    chk("big_cpu_rst_n", cpu_rst_n, 0);
    chk("big_busy", busy, 0);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) @(negedge clk);
    chk("stray_byte_ready", byte_ready, 0);
    byte_valid = 1'b0;

    // Zero-length load.
    wq.delete();
    do_load(0, 0);
    chk("zero_latency", lat, CK);
    chk("zero_iready", iready, 1);
    chk("zero_err", err, 0);

    // Full-depth load.
    wq.delete();
    for (int i = 0; i < ROW; i++) wq.push_back((32'(i) * 32'h01010101) ^ 32'hC3000000);
    do_load(0, 0);
    chk("row_last_addr", last_addr, ROW - 1);
    chk("row_latency", lat, 5*ROW + CK);
    chk("row_iready", iready, 1);

    // Reset after one word plus two bytes of the next; reload from scratch.
    begin
      wr_t e;
      pulse_start(2);
      e.a = '0;
      e.d = 32'hCAFEF00D;
      expq.push_back(e);
      send_word(32'hCAFEF00D, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 0);
    chk("midrst_wdata", wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    wq = {32'h44332211};
    do_load(0, 0);
    chk("reload_iready", iready, 1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    wq = {32'h00000013};
    do_load(0, 0);
    chk("ck_ok_iready", iready, 1);
    chk("ck_ok_err", err, 0);
    do_load(0, 32'h00000007);   // sends checksum 0x14
    chk("ck_bad_err", err, 1);
    chk("ck_bad_iready", iready, 0);
    chk("ck_bad_cpu_rst_n", cpu_rst_n, 0);
`endif

    repeat (3) @(negedge clk);
    chk("expq_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program loading into the instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Issues one write per word to the imem write port.
- When the programmed word count is reached: drives iready high to enable imem reads and releases the core reset. Sits between the host/UART byte source, imem and the core reset.

Parameters:
- ROW, 256, imem depth in words; must match the imem ROW.
- ADDR_W, $clog2(ROW), word-address width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begin a load
- word_count  input  ADDR_W+1  program length in words, sampled on start
- byte_valid  input  1  byte source has data
- byte_data  input  8  byte payload
- byte_ready  output  1  loader accepts a byte this cycle
- we  output  1  imem write strobe, one cycle per word
- waddr  output  ADDR_W  imem word address
- wdata  output  32  imem write data
- iready  output  1  imem contents valid; gates imem reads
- cpu_rst_n  output  1  core reset, active-low
- busy  output  1  load in progress
- err  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; byte_ready=0, we=0, waddr=0, wdata=0, iready=0, cpu_rst_n=0, busy=0, err=0. Partial word, byte index and word counter are cleared. Reset mid-load discards everything; nothing resumes.
- All outputs are registered.
- State IDLE:
  - start with word_count==0 -> DONE; err=0.
  - start with word_count>ROW -> stay IDLE; err=1.
  - start with any other count -> LOAD; latch count; err=0; word counter=0; byte index=0.
- State LOAD:
  - busy=1, byte_ready=1, iready=0, cpu_rst_n=0.
  - A byte is accepted when byte_valid && byte_ready. Byte index k (0..3) goes into wdata bits [8k+7:8k], so the first byte is the LSB.
  - The cycle after the 4th byte is accepted: we=1 for exactly one cycle, waddr=word counter, wdata=packed word. The word counter then increments.
  - During the we cycle byte_ready=0, so no byte is accepted while a write is issued.
  - After the write of word (count-1): next state is DONE.
  - start is ignored in LOAD.
- State DONE:
  - iready=1, cpu_rst_n=1, busy=0, byte_ready=0.
  - start -> LOAD on the next cycle; iready=0 and cpu_rst_n=0 in that same cycle (the core is re-held).
  - err is reset to 0 by start in DONE.
- Stray bytes arriving in IDLE or DONE are not accepted (byte_ready=0).
- word_count==ROW is legal; waddr reaches ROW-1 and the counter width prevents wrap.
- Min load latency: 5*count cycles plus 1 cycle from start to LOAD, with byte_valid held high.

Optional Feature:
- Macro IMEM_BOOT_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last word, the loader accepts 4 more bytes (little-endian) as a checksum. Expected value = sum of all written words mod 2^32.
  - Match -> DONE.
  - Mismatch -> IDLE; err=1; iready=0 and cpu_rst_n=0 stay low.
  - The checksum bytes produce no we.
  - word_count==0 still needs the 4 checksum bytes; expected value is 0.
- Disabled: no checksum phase; the transition to DONE is as above.

Decomposition:
- imem_pkg:
  - state encoding (IDLE, LOAD, CHECK, DONE)
  - default ROW constant
  - word width constant 32
  - byte-lane count 4
- One sub-module is natural: imem_word_packer. It holds the byte index, the shift/assembly register and the word_done pulse, and is reused for the checksum word.

Test Plan:
- Reset released, no start -> iready=0, cpu_rst_n=0, byte_ready=0 held indefinitely.
- start with word_count=2; bytes 13,00,00,00,93,00,10,00 streamed continuously:
  - we at addr 0 with data 0x00000013;
  - we at addr 1 with data 0x00100093;
  - then iready=1 and cpu_rst_n=1.
- Gapped byte_valid (one byte every 3 cycles) with word_count=1, bytes EF,BE,AD,DE -> single we, wdata=0xDEADBEEF; no duplicate or missed bytes.
- Boundary counts:
  - start with word_count=ROW+1 -> err=1, stays IDLE;
  - start with word_count=0 -> DONE next cycle with iready=1;
  - word_count=ROW -> last waddr=ROW-1.
- rst_n dropped after 2 bytes of word 1; reload with word_count=1 -> the first we carries only the new 4 bytes at addr 0.
- CHECKSUM_EN, word_count=1:
  - word 0x00000013 with checksum 0x00000013 -> DONE;
  - checksum 0x00000014 -> err=1, iready=0.
